// File: rtl/idex_hazard_ctrl_pkg.sv
// Shared types and constants for the ID/EX hazard controller and its forwarding compare.
package idex_ctrl_pkg;

    localparam int REGISTER_SIZE_DEF  = 6;
    localparam int ALU_FUNCT_BITS_DEF = 3;
    localparam int CNT_W              = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        MULTI = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/idex_fwd_unit.sv
// Forwarding select for one EX source operand; the MEM result wins over the WB result.
module idex_fwd_unit
    import idex_ctrl_pkg::*;
#(
    parameter int REG_W = REGISTER_SIZE_DEF
) (
    input  logic [REG_W-1:0] i_rs,
    input  logic             i_reg_write_m,
    input  logic [REG_W-1:0] i_write_reg_m,
    input  logic             i_reg_write_w,
    input  logic [REG_W-1:0] i_write_reg_w,
    output logic [1:0]       o_fwd
);

    always_comb begin
        o_fwd = FWD_RF;
        if (i_reg_write_m && (i_write_reg_m != '0) && (i_write_reg_m == i_rs))
            o_fwd = FWD_MEM;
        else if (i_reg_write_w && (i_write_reg_w != '0) && (i_write_reg_w == i_rs))
            o_fwd = FWD_WB;
    end

endmodule

// File: rtl/idex_hazard_ctrl.sv
// Stall/flush/forward controller beside the ID/EX register, with the ALU2 multi-cycle FSM.
// IDEX_FORWARD_EN enables forwarding; without it every pending write to a decode source stalls.
module idex_hazard_ctrl
    import idex_ctrl_pkg::*;
#(
    parameter int                            REGISTER_SIZE  = REGISTER_SIZE_DEF,
    parameter int                            ALU_FUNCT_BITS = ALU_FUNCT_BITS_DEF,
    parameter logic [2**ALU_FUNCT_BITS-1:0]  MC_OPMASK      = 8'b1100_0000,
    parameter int                            MC_LAT         = 4
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic [REGISTER_SIZE-1:0]  RsD,
    input  logic [REGISTER_SIZE-1:0]  RtD,
    input  logic [REGISTER_SIZE-1:0]  RsE,
    input  logic [REGISTER_SIZE-1:0]  RtE,
    input  logic [REGISTER_SIZE-1:0]  WriteRegE,
    input  logic                      MemtoRegE,
    input  logic                      RegWriteE,
    input  logic [REGISTER_SIZE-1:0]  WriteRegM,
    input  logic                      RegWriteM,
    input  logic [REGISTER_SIZE-1:0]  WriteRegW,
    input  logic                      RegWriteW,
    input  logic [ALU_FUNCT_BITS-1:0] ALU2CntrlE,
    input  logic                      ValidE,
    input  logic                      BranchTakenE,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic [1:0]                ForwardAE,
    output logic [1:0]                ForwardBE,
    output logic                      ALU2Busy,
    output logic                      ALU2Done
);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_mc_start;
    logic             w_load_use;
    logic [1:0]       w_fwd_a, w_fwd_b;

    idex_fwd_unit #(.REG_W(REGISTER_SIZE)) u_fwd_a (
        .i_rs          (RsE),
        .i_reg_write_m (RegWriteM),
        .i_write_reg_m (WriteRegM),
        .i_reg_write_w (RegWriteW),
        .i_write_reg_w (WriteRegW),
        .o_fwd         (w_fwd_a)
    );

    idex_fwd_unit #(.REG_W(REGISTER_SIZE)) u_fwd_b (
        .i_rs          (RtE),
        .i_reg_write_m (RegWriteM),
        .i_write_reg_m (WriteRegM),
        .i_reg_write_w (RegWriteW),
        .i_write_reg_w (WriteRegW),
        .o_fwd         (w_fwd_b)
    );

    assign w_mc_start = ValidE && MC_OPMASK[ALU2CntrlE] && (MC_LAT > 1);

`ifdef IDEX_FORWARD_EN
    assign w_load_use = MemtoRegE && RegWriteE && (WriteRegE != '0)
                        && ((WriteRegE == RsD) || (WriteRegE == RtD));
    assign ForwardAE  = RST_N ? w_fwd_a : FWD_RF;
    assign ForwardBE  = RST_N ? w_fwd_b : FWD_RF;
`else
    // No bypass paths: any in-flight write to a decode source must retire first.
    assign w_load_use =
        (RegWriteE && (WriteRegE != '0) && ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
        (RegWriteM && (WriteRegM != '0) && ((WriteRegM == RsD) || (WriteRegM == RtD))) ||
        (RegWriteW && (WriteRegW != '0) && ((WriteRegW == RsD) || (WriteRegW == RtD)));
    assign ForwardAE  = FWD_RF;
    assign ForwardBE  = FWD_RF;

    logic w_unused_fwd;
    assign w_unused_fwd = ^{w_fwd_a, w_fwd_b, MemtoRegE};
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        ALU2Busy    = 1'b0;
        ALU2Done    = 1'b0;
        if (!RST_N) begin
            FlushE      = 1'b1;
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_mc_start) begin
                        w_state_nxt = MULTI;
                        w_cnt_nxt   = CNT_W'(MC_LAT - 2);
                    end
                    // A taken branch squashes the dependent instruction, so no stall is needed.
                    if (BranchTakenE) begin
                        FlushD = 1'b1;
                        FlushE = 1'b1;
                    end else if (w_load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MULTI: begin
                    StallF   = 1'b1;
                    StallD   = 1'b1;
                    StallE   = 1'b1;
                    ALU2Busy = 1'b1;
                    if (r_cnt == '0) begin
                        ALU2Done    = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// Table-driven bench for idex_hazard_ctrl; expectations follow IDEX_FORWARD_EN when defined.
module tb_idex_hazard_ctrl;
    import idex_ctrl_pkg::*;

`ifdef IDEX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    // {StallF,StallD,StallE,FlushD,FlushE, ForwardAE, ForwardBE, ALU2Busy,ALU2Done}
    localparam logic [10:0] E_NONE = 11'b00000_00_00_00;
    localparam logic [10:0] E_LU   = 11'b11001_00_00_00;
    localparam logic [10:0] E_BR   = 11'b00011_00_00_00;
    localparam logic [10:0] E_RST  = 11'b00001_00_00_00;
    localparam logic [10:0] E_MC   = 11'b11100_00_00_10;
    localparam logic [10:0] E_MCD  = 11'b11100_00_00_11;
    localparam logic [10:0] E_FA_M = 11'b00000_10_00_00;
    localparam logic [10:0] E_FA_W = 11'b00000_01_00_00;
    localparam logic [10:0] E_FB_M = 11'b00000_00_10_00;

    typedef struct {
        logic       rst_n;
        logic [5:0] rsd, rtd, rse, rte, wre, wrm, wrw;
        logic       mem, rwe, rwm, rww, valid, br;
        logic [2:0] alu2;
    } vin_t;

    typedef struct {
        string       name;
        vin_t        vi;
        logic [10:0] exp;
    } vec_t;

    typedef struct {
        string       name;
        logic [10:0] exp;
    } sb_t;

    logic       CLK, RST_N;
    logic [5:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       MemtoRegE, RegWriteE, RegWriteM, RegWriteW, ValidE, BranchTakenE;
    logic [2:0] ALU2CntrlE;
    logic       StallF, StallD, StallE, FlushD, FlushE, ALU2Busy, ALU2Done;
    logic [1:0] ForwardAE, ForwardBE;

    int   total = 0;
    int   bad   = 0;
    vec_t tbl[$];
    sb_t  sb_q[$];

    idex_hazard_ctrl dut (
        .CLK(CLK), .RST_N(RST_N),
        .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
        .WriteRegM(WriteRegM), .RegWriteM(RegWriteM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .ALU2CntrlE(ALU2CntrlE), .ValidE(ValidE), .BranchTakenE(BranchTakenE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALU2Busy(ALU2Busy), .ALU2Done(ALU2Done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic vin_t mk(input logic [5:0] rsd, rtd, rse, rte, wre,
                                input logic mem, rwe,
                                input logic [5:0] wrm, input logic rwm,
                                input logic [5:0] wrw, input logic rww);
        vin_t v;
        v.rst_n = 1'b1;
        v.rsd = rsd; v.rtd = rtd; v.rse = rse; v.rte = rte; v.wre = wre;
        v.mem = mem; v.rwe = rwe;
        v.wrm = wrm; v.rwm = rwm; v.wrw = wrw; v.rww = rww;
        v.valid = 1'b0; v.br = 1'b0; v.alu2 = 3'd0;
        return v;
    endfunction

    function automatic vin_t mc(input logic rst_n, input logic valid, input logic [2:0] alu2,
                                input logic br);
        vin_t v;
        v = mk(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0);
        v.rst_n = rst_n; v.valid = valid; v.alu2 = alu2; v.br = br;
        return v;
    endfunction

    task automatic add(input string n, input vin_t v, input logic [10:0] e);
        vec_t t;
        t.name = n; t.vi = v; t.exp = e;
        tbl.push_back(t);
    endtask

    // One cycle: drive after the rising edge, queue the expectation, check at the falling edge.
    task automatic step(input string n, input vin_t v, input logic [10:0] e);
        sb_t         s;
        logic [10:0] got;
        @(posedge CLK);
        #1;
        RST_N = v.rst_n;
        RsD = v.rsd; RtD = v.rtd; RsE = v.rse; RtE = v.rte;
        WriteRegE = v.wre; MemtoRegE = v.mem; RegWriteE = v.rwe;
        WriteRegM = v.wrm; RegWriteM = v.rwm; WriteRegW = v.wrw; RegWriteW = v.rww;
        ValidE = v.valid; BranchTakenE = v.br; ALU2CntrlE = v.alu2;
        s.name = n; s.exp = e;
        sb_q.push_back(s);
        @(negedge CLK);
        s = sb_q.pop_front();
        got = {StallF, StallD, StallE, FlushD, FlushE, ForwardAE, ForwardBE, ALU2Busy, ALU2Done};
        total++;
        if (got !== s.exp) begin
            bad++;
            $display("FAIL %s: got=%b want=%b", s.name, got, s.exp);
        end
    endtask

    initial begin
        vin_t v;
        RST_N = 1'b0;
        RsD = '0; RtD = '0; RsE = '0; RtE = '0;
        WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
        MemtoRegE = 1'b0; RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        ValidE = 1'b0; BranchTakenE = 1'b0; ALU2CntrlE = '0;

        //        rsd    rtd    rse    rte    wre    mem  rwe  wrm    rwm  wrw    rww
        add("idle",     mk(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0), E_NONE);
        add("lu_e5",    mk(6'd5, 6'd2, 6'd0, 6'd0, 6'd5, 1'b1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0), E_LU);
        add("lu_m5",    mk(6'd5, 6'd2, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd5, 1'b1, 6'd0, 1'b0), FWD ? E_NONE : E_LU);
        add("lu_w5",    mk(6'd5, 6'd2, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd5, 1'b1), FWD ? E_NONE : E_LU);
        add("lu_clear", mk(6'd5, 6'd2, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0), E_NONE);
        add("lu_r0",    mk(6'd0, 6'd2, 6'd0, 6'd0, 6'd0, 1'b1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0), E_NONE);
        v = mk(6'd5, 6'd2, 6'd0, 6'd0, 6'd5, 1'b1, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0);
        v.br = 1'b1;
        add("br_lu",    v, E_BR);
        add("fwd_mw9",  mk(6'd1, 6'd2, 6'd9, 6'd0, 6'd0, 1'b0, 1'b0, 6'd9, 1'b1, 6'd9, 1'b1), FWD ? E_FA_M : E_NONE);
        add("fwd_w9",   mk(6'd1, 6'd2, 6'd9, 6'd0, 6'd0, 1'b0, 1'b0, 6'd9, 1'b0, 6'd9, 1'b1), FWD ? E_FA_W : E_NONE);
        add("fwd_b4",   mk(6'd1, 6'd2, 6'd0, 6'd4, 6'd0, 1'b0, 1'b0, 6'd4, 1'b1, 6'd4, 1'b1), FWD ? E_FB_M : E_NONE);
        add("fwd_r0",   mk(6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b1, 6'd0, 1'b1), E_NONE);
        add("m3_rtd",   mk(6'd1, 6'd3, 6'd0, 6'd3, 6'd0, 1'b0, 1'b0, 6'd3, 1'b1, 6'd0, 1'b0), FWD ? E_FB_M : E_LU);
        add("w7_rsd",   mk(6'd7, 6'd2, 6'd7, 6'd0, 6'd0, 1'b0, 1'b0, 6'd0, 1'b0, 6'd7, 1'b1), FWD ? E_FA_W : E_LU);
        add("e6_alu",   mk(6'd1, 6'd6, 6'd0, 6'd0, 6'd6, 1'b0, 1'b1, 6'd0, 1'b0, 6'd0, 1'b0), FWD ? E_NONE : E_LU);
        add("lu_nowr",  mk(6'd5, 6'd2, 6'd0, 6'd0, 6'd5, 1'b1, 1'b0, 6'd0, 1'b0, 6'd0, 1'b0), E_NONE);

        step("rst_init", mc(1'b0, 1'b0, 3'd0, 1'b0), E_RST);
        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i].name, tbl[i].vi, tbl[i].exp);

        // Multi-cycle op 7, then a back-to-back op 6 interrupted by reset.
        step("mc_enter",  mc(1'b1, 1'b1, 3'd7, 1'b0), E_NONE);
        step("mc_busy1",  mc(1'b1, 1'b1, 3'd7, 1'b0), E_MC);
        step("mc_busy2",  mc(1'b1, 1'b1, 3'd7, 1'b1), E_MC);
        step("mc_done",   mc(1'b1, 1'b1, 3'd7, 1'b0), E_MCD);
        step("mc2_enter", mc(1'b1, 1'b1, 3'd6, 1'b0), E_NONE);
        step("mc2_busy1", mc(1'b1, 1'b1, 3'd6, 1'b0), E_MC);
        v = mk(6'd5, 6'd2, 6'd9, 6'd9, 6'd5, 1'b1, 1'b1, 6'd9, 1'b1, 6'd9, 1'b1);
        v.rst_n = 1'b0; v.valid = 1'b1; v.alu2 = 3'd6;
        for (int i = 0; i < 3; i++)
            step("rst_mid", v, E_RST);
        for (int i = 0; i < 4; i++)
            step("rst_after", mc(1'b1, 1'b0, 3'd6, 1'b0), E_NONE);
        // Op 5 is single-cycle: no MULTI entry.
        step("sc_op",     mc(1'b1, 1'b1, 3'd5, 1'b0), E_NONE);
        step("sc_op2",    mc(1'b1, 1'b0, 3'd5, 1'b0), E_NONE);
        // Multi-cycle op with ValidE low is a bubble.
        step("mc_bubble", mc(1'b1, 1'b0, 3'd7, 1'b0), E_NONE);
        step("mc_bub2",   mc(1'b1, 1'b0, 3'd7, 1'b0), E_NONE);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
